fact_seq_unit: RTL and testbench
================================

Name: fact_seq_unit

Overview:
- Iterative factorial engine with a go/done handshake. It computes result = n! for a 4-bit operand.
- Internally it is a control FSM plus a datapath: down-counter, product register, multiplier, and a "count > 1" magnitude compare that steers the loop.
- It sits behind the memory-mapped I/O interface of the pipelined MIPS core as a slave accelerator. The I/O wrapper drives go and n, and polls done, err and result.

Parameters:
- DATA_WIDTH, 32, width of the product register and the result output.
- N_WIDTH, 4, width of the operand n.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- go  input  1  start request, level-sensitive, sampled only in IDLE.
- n  input  N_WIDTH  operand, captured on the cycle go is accepted.
- done  output  1  high while in DONE; result and err are valid.
- err  output  1  operand out of range (only with the optional feature); valid while done=1.
- busy  output  1  high in LOAD, CHECK and MULT.
- result  output  DATA_WIDTH  n! while done=1, otherwise 0.

Behaviour:
- Reset: asynchronous on rst_n low.
  - State goes to IDLE; cnt, n_q and prod clear to 0.
  - done, err and busy are 0; result is 0.
  - Reset asserted mid-computation aborts the computation with no residue.
- FSM states are IDLE, LOAD, CHECK, MULT, DONE. Outputs are Moore, decoded from the registered state.
- IDLE: if go=1 at the clock edge, capture n_q<=n and go to LOAD. Otherwise stay in IDLE.
- LOAD (1 cycle): cnt<=n_q, prod<=1, go to CHECK.
- CHECK (1 cycle): the comparator evaluates gt = (cnt > 1), unsigned.
  - gt=1: go to MULT.
  - gt=0: go to DONE.
- MULT (1 cycle): prod <= (prod * cnt) truncated to the low DATA_WIDTH bits; cnt <= cnt - 1; go to CHECK.
- DONE: done=1, result=prod.
  - Stays in DONE while go=1.
  - Goes to IDLE when go=0. This is a 4-phase handshake: no restart without go being deasserted first.
- Latency, counting the go-accept edge as edge 0: done is visible after edge 2*max(n,1).
  - n=0 and n=1 give result 1 after edge 2.
  - n=5 gives 120 after edge 10.
- Boundary conditions:
  - Changes on n or go during LOAD/CHECK/MULT are ignored.
  - cnt never underflows, because MULT is entered only when cnt >= 2.
  - Without the optional feature, n >= 13 wraps modulo 2^DATA_WIDTH. For example, 13! gives 0x17328CC00.
- err is 0 whenever the optional feature is excluded.

Optional Feature:
- Macro: FACT_RANGE_CHECK_EN.
- Defined: LOAD compares n_q against constant N_MAX=12 (largest n with n! fitting in 32 bits).
  - If n_q > N_MAX: prod<=0, err<=1, and the FSM goes directly to DONE, so done is visible after edge 2.
  - err clears on the next go acceptance and on reset.
- Not defined: no range compare, err is tied to 0, and the result wraps as stated in Behaviour.

Decomposition:
- Package fact_pkg holds:
  - the state enum (IDLE, LOAD, CHECK, MULT, DONE);
  - localparam N_MAX = 12;
  - the default DATA_WIDTH and N_WIDTH values.
- Sub-module fact_dp holds cnt, n_q, prod, the multiplier, the gt compare and the range compare.
  - Control inputs: ld, mul_en, clr_err, set_err.
  - Status outputs: gt, over.
- fact_seq_unit instantiates fact_dp and contains the FSM and the output decode.

Test Plan:
- Reset during MULT with n=7: drop rst_n for one cycle → done=0, busy=0, result=0 immediately (asynchronous); a fresh go with n=3 then gives result 6 after edge 6.
- n=0 and n=1, go held high: done after edge 2, result=1, err=0. With go still high, done stays 1; drop go → IDLE next cycle.
- n=5: busy is high for edges 1–9, done after edge 10, result=0x00000078. Changing n to 9 mid-run has no effect.
- n=12: result=0x1C8CFC00 (479001600) after edge 24, err=0.
- n=13:
  - With FACT_RANGE_CHECK_EN: err=1, result=0, done after edge 2.
  - Without it: result=0x7328CC00, err=0.
- Back-to-back: run n=4 (result 24), deassert go for one cycle, run n=3 → result 6, with no stale err or prod carried over.

Source files
------------

// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared definitions for the iterative factorial engine (fact_seq_unit).
//   - state_e        : control FSM states
//   - N_MAX          : largest operand whose factorial fits in 32 bits
//   - DATA_WIDTH_DEF : default product / result width
//   - N_WIDTH_DEF    : default operand width
// Optional feature macro: FACT_RANGE_CHECK_EN (operand range check).
// -----------------------------------------------------------------------------
package fact_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int N_WIDTH_DEF    = 4;
    localparam int N_MAX          = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        MULT  = 3'd3,
        DONE  = 3'd4
    } state_e;

endpackage : fact_pkg

// File: rtl/fact_dp.sv
// -----------------------------------------------------------------------------
// fact_dp
// Datapath of the factorial engine: operand latch, down-counter, product
// register, multiplier, "cnt > 1" compare and (optionally) the range compare.
// Optional feature macro: FACT_RANGE_CHECK_EN.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   cap_i       : capture n_i into n_q (go accepted)
//   n_i         : operand
//   ld_i        : load cnt/prod from n_q (LOAD state)
//   mul_en_i    : prod <= prod*cnt, cnt <= cnt-1 (MULT state)
//   clr_err_i   : clear the error flag
//   set_err_i   : set the error flag
//   gt_o        : cnt > 1 (unsigned)
//   over_o      : n_q > N_MAX (0 without the range check)
//   prod_o      : product register
//   err_o       : error flag (0 without the range check)
// -----------------------------------------------------------------------------
module fact_dp
    import fact_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_WIDTH    = N_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_i,
    input  logic [N_WIDTH-1:0]    n_i,
    input  logic                  ld_i,
    input  logic                  mul_en_i,
    input  logic                  clr_err_i,
    input  logic                  set_err_i,
    output logic                  gt_o,
    output logic                  over_o,
    output logic [DATA_WIDTH-1:0] prod_o,
    output logic                  err_o
);

    logic [N_WIDTH-1:0]    n_q,    n_d;
    logic [N_WIDTH-1:0]    cnt_q,  cnt_d;
    logic [DATA_WIDTH-1:0] prod_q, prod_d;
    logic [DATA_WIDTH-1:0] mul_res;

    // Product evaluated in a DATA_WIDTH context, so it wraps modulo 2^DATA_WIDTH.
    assign mul_res = prod_q * DATA_WIDTH'(cnt_q);
    assign gt_o    = (cnt_q > N_WIDTH'(1));

`ifdef FACT_RANGE_CHECK_EN
    logic err_q, err_d;

    assign over_o = (n_q > N_WIDTH'(N_MAX));

    always_comb begin
        err_d = err_q;
        if (clr_err_i) err_d = 1'b0;
        if (set_err_i) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err_o = err_q;
`else
    logic unused_err_ctl;

    assign over_o         = 1'b0;
    assign err_o          = 1'b0;
    assign unused_err_ctl = clr_err_i ^ set_err_i;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        n_d    = n_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (cap_i) n_d = n_i;
        if (ld_i) begin
            // An out-of-range operand loads cnt=0 so CHECK falls straight
            // through to DONE, keeping done timing identical to n<=1.
            cnt_d  = over_o ? '0 : n_q;
            prod_d = over_o ? '0 : DATA_WIDTH'(1);
        end else if (mul_en_i) begin
            prod_d = mul_res;
            cnt_d  = cnt_q - N_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // update together from pre-edge values.
        if (!rst_n) begin
            n_q    <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            n_q    <= n_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule : fact_dp

// File: rtl/fact_seq_unit.sv
// -----------------------------------------------------------------------------
// fact_seq_unit
// Iterative factorial engine (result = n!) with a 4-phase go/done handshake.
// Control FSM plus the fact_dp datapath.
// Optional feature macro: FACT_RANGE_CHECK_EN (n > N_MAX flagged via err).
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   go      : start request, sampled only in IDLE
//   n       : operand, captured when go is accepted
//   done    : high in DONE; result and err valid
//   err     : operand out of range (range check build only)
//   busy    : high in LOAD, CHECK and MULT
//   result  : n! while done=1, otherwise 0
// -----------------------------------------------------------------------------
module fact_seq_unit
    import fact_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N_WIDTH    = N_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [N_WIDTH-1:0]    n,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] result
);

    state_e                state_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  cap, ld, mul_en;
    logic                  gt, over;
    logic [DATA_WIDTH-1:0] prod;

    assign cap    = (state_q == IDLE) && go;
    assign ld     = (state_q == LOAD);
    assign mul_en = (state_q == MULT);

    fact_dp #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_WIDTH    (N_WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_i     (cap),
        .n_i       (n),
        .ld_i      (ld),
        .mul_en_i  (mul_en),
        .clr_err_i (cap),
        .set_err_i (ld && over),
        .gt_o      (gt),
        .over_o    (over),
        .prod_o    (prod),
        .err_o     (err)
    );

    // Moore outputs are registered alongside the state, set from the state
    // being entered so they line up exactly with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (gt) begin
                        state_q <= MULT;
                    end else begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                MULT: begin
                    state_q <= CHECK;
                end
                DONE: begin
                    // 4-phase handshake: leave only after go drops.
                    if (!go) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign result = done_q ? prod : '0;

endmodule : fact_seq_unit

// File: tb/tb_fact_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_fact_seq_unit
// Self-checking bench for fact_seq_unit: directed table, hand-written corner
// sequences (async reset mid-run, go held in DONE, back-to-back runs) and
// randomized operands checked against an arithmetic factorial model.
// Honours FACT_RANGE_CHECK_EN for the expected err/result/latency.
// -----------------------------------------------------------------------------
module tb_fact_seq_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic [3:0]  n_in;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  n;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_lat;
        int          hold;
        bit          chg;
    } vec_t;

    fact_seq_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .go     (go),
        .n      (n_in),
        .done   (done),
        .err    (err),
        .busy   (busy),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Reference: n! by plain arithmetic, truncated to 32 bits.
    function automatic logic [31:0] ref_fact(input int nv);
        longint unsigned p = 1;
        for (int i = 2; i <= nv; i++) p = p * longint'(i);
        return p[31:0];
    endfunction

    function automatic vec_t ref_vec(input int nv, input int hold);
        vec_t v;
        v.n    = 4'(nv);
        v.hold = hold;
        v.chg  = 1'b0;
`ifdef FACT_RANGE_CHECK_EN
        if (nv > 12) begin
            v.exp_res = 32'd0;
            v.exp_err = 1'b1;
            v.exp_lat = 2;
            return v;
        end
`endif
        v.exp_res = ref_fact(nv);
        v.exp_err = 1'b0;
        v.exp_lat = (nv < 1) ? 2 : 2 * nv;
        return v;
    endfunction

    // One handshake: raise go, watch busy until done, check result/err/latency,
    // optionally hold go in DONE, then drop go and confirm return to IDLE.
    task automatic run_op(input vec_t v, input string tag);
        int lat = -1;
        @(negedge clk);
        go   = 1'b1;
        n_in = v.n;
        @(posedge clk);               // edge 0: go accepted
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            check($sformatf("%s_busy_e%0d", tag, k), 64'(busy), 64'd1);
            check($sformatf("%s_res0_e%0d", tag, k), 64'(result), 64'd0);
            if (v.chg && k == 2) n_in = 4'd9;
        end
        check({tag, "_lat"},    64'(lat),    64'(v.exp_lat));
        check({tag, "_result"}, 64'(result), 64'(v.exp_res));
        check({tag, "_err"},    64'(err),    64'(v.exp_err));
        check({tag, "_busy_d"}, 64'(busy),   64'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_hold%0d_done", tag, h), 64'(done), 64'd1);
            check($sformatf("%s_hold%0d_res", tag, h), 64'(result), 64'(v.exp_res));
        end
        @(negedge clk);
        go = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_idle_done"}, 64'(done),   64'd0);
        check({tag, "_idle_res"},  64'(result), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy),   64'd0);
    endtask

    vec_t tbl[6];

    initial begin
        rst_n = 1'b0;
        go    = 1'b0;
        n_in  = 4'd0;

        // Directed table, expectations written out by hand.
        tbl[0] = '{n: 4'd0,  exp_res: 32'd1,          exp_err: 1'b0, exp_lat: 2,  hold: 3, chg: 1'b0};
        tbl[1] = '{n: 4'd1,  exp_res: 32'd1,          exp_err: 1'b0, exp_lat: 2,  hold: 2, chg: 1'b0};
        tbl[2] = '{n: 4'd5,  exp_res: 32'h0000_0078,  exp_err: 1'b0, exp_lat: 10, hold: 0, chg: 1'b1};
        tbl[3] = '{n: 4'd12, exp_res: 32'h1C8C_FC00,  exp_err: 1'b0, exp_lat: 24, hold: 0, chg: 1'b0};
`ifdef FACT_RANGE_CHECK_EN
        tbl[4] = '{n: 4'd13, exp_res: 32'd0,          exp_err: 1'b1, exp_lat: 2,  hold: 1, chg: 1'b0};
`else
        tbl[4] = '{n: 4'd13, exp_res: 32'h7328_CC00,  exp_err: 1'b0, exp_lat: 26, hold: 1, chg: 1'b0};
`endif
        tbl[5] = '{n: 4'd3,  exp_res: 32'd6,          exp_err: 1'b0, exp_lat: 6,  hold: 0, chg: 1'b0};

        // Reset state.
        #12;
        check("rst_done",   64'(done),   64'd0);
        check("rst_busy",   64'(busy),   64'd0);
        check("rst_err",    64'(err),    64'd0);
        check("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

        // Asynchronous reset in MULT with n=7.
        @(negedge clk);
        go   = 1'b1;
        n_in = 4'd7;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("arst_pre_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_done",   64'(done),   64'd0);
        check("arst_busy",   64'(busy),   64'd0);
        check("arst_result", 64'(result), 64'd0);
        check("arst_err",    64'(err),    64'd0);
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(ref_vec(3, 0), "arst_n3");

        // Back-to-back: 4 then 3, and an out-of-range run followed by 3.
        run_op(ref_vec(4, 0), "b2b_n4");
        run_op(ref_vec(3, 0), "b2b_n3");
        run_op(ref_vec(15, 0), "b2b_n15");
        run_op(ref_vec(3, 0), "b2b_n3b");

        // Randomized operands against the arithmetic model.
        for (int r = 0; r < 24; r++) begin
            int nv   = int'($urandom_range(0, 15));
            int hold = int'($urandom_range(0, 2));
            run_op(ref_vec(nv, hold), $sformatf("rnd%0d_n%0d", r, nv));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fact_seq_unit
